// File: rtl/tdoa_collector.sv
// Collects one timestamp per microphone channel into an acoustic event and presents
// per-channel deltas against the earliest stamp. Optional drop counter: TDOA_DROP_CNT_EN.

// One channel: capture handshake, stamp register and delta register.
module tdoa_lane #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en,
  input  logic             clr,
  input  logic             ld,
  input  logic             ts_valid,
  input  logic [WIDTH-1:0] ts,
  input  logic [WIDTH-1:0] ref_ts,
  output logic             cap,
  output logic             ack,
  output logic             mask,
  output logic [WIDTH-1:0] stamp,
  output logic [WIDTH-1:0] delta
);
  // The ack guard keeps a stamp whose source has not yet seen its ack from being taken twice.
  assign cap = cap_en & ts_valid & ~mask & ~ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack   <= 1'b0;
      mask  <= 1'b0;
      stamp <= '0;
      delta <= '0;
    end else begin
      ack <= cap;
      if (clr)      mask <= 1'b0;
      else if (cap) mask <= 1'b1;
      if (cap) stamp <= ts;
      if (ld)  delta <= stamp - ref_ts;
    end
  end
endmodule

module tdoa_collector #(
  parameter int NUM_CH = 3,
  parameter int WIDTH  = 32,
  parameter int WINDOW = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] ts_in,
  input  logic [NUM_CH-1:0]       ts_valid,
  output logic [NUM_CH-1:0]       ts_ack,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [NUM_CH*WIDTH-1:0] evt_delta,
  output logic [2:0]              evt_ref_ch
`ifdef TDOA_DROP_CNT_EN
  ,
  output logic [15:0]             drop_cnt
`endif
);
  localparam int CW = $clog2(WINDOW + 1);
  localparam logic [CW-1:0] WIN = CW'(WINDOW);
  localparam logic signed [WIDTH-1:0] SZERO = '0;

  typedef enum logic [1:0] {IDLE, COLLECT, CALC, PRESENT} state_t;

  state_t                         state;
  logic [CW-1:0]                  cnt;
  logic [NUM_CH-1:0]              cap, mask;
  logic [NUM_CH-1:0][WIDTH-1:0]   stamp, delta;
  logic                           cap_en, clr, ld, timeout, full_now, full_nxt;
  logic [WIDTH-1:0]               ref_ts;
  logic [2:0]                     ref_sel;
  logic signed [WIDTH-1:0]        sdiff;
  int                             ref_idx;

  assign full_now = &mask;
  assign full_nxt = &(mask | cap);
  assign cap_en   = (state == IDLE) || ((state == COLLECT) && (cnt <= WIN));
  // Captures on the final window edge still count toward completing the event.
  assign timeout  = (state == COLLECT) && (cnt == WIN) && !full_nxt;
  assign clr      = timeout || ((state == PRESENT) && evt_ready);
  assign ld       = (state == CALC);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    tdoa_lane #(.WIDTH(WIDTH)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .cap_en   (cap_en),
      .clr      (clr),
      .ld       (ld),
      .ts_valid (ts_valid[i]),
      .ts       (ts_in[i*WIDTH +: WIDTH]),
      .ref_ts   (ref_ts),
      .cap      (cap[i]),
      .ack      (ts_ack[i]),
      .mask     (mask[i]),
      .stamp    (stamp[i]),
      .delta    (delta[i])
    );
    assign evt_delta[i*WIDTH +: WIDTH] = delta[i];
  end

  // Wrap-aware earliest stamp; strict compare keeps the lowest index on ties.
  always_comb begin
    ref_idx = 0;
    sdiff   = '0;
    for (int i = 1; i < NUM_CH; i++) begin
      sdiff = stamp[i] - stamp[ref_idx];
      if (sdiff < SZERO) ref_idx = i;
    end
    ref_sel = 3'(ref_idx);
    ref_ts  = stamp[ref_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      evt_valid  <= 1'b0;
      evt_ref_ch <= '0;
    end else begin
      case (state)
        IDLE: if (|cap) begin
          state <= COLLECT;
          cnt   <= '0;
        end
        COLLECT: begin
          if (cnt != WIN) cnt <= cnt + 1'b1;
          if (full_now)     state <= CALC;
          else if (timeout) state <= IDLE;
        end
        CALC: begin
          state      <= PRESENT;
          evt_valid  <= 1'b1;
          evt_ref_ch <= ref_sel;
        end
        PRESENT: if (evt_ready) begin
          state     <= IDLE;
          evt_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TDOA_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                drop_cnt <= '0;
    else if (timeout && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_tdoa_collector.sv
// Scoreboard bench for tdoa_collector: expected events are queued at stimulus time and
// compared when the DUT completes its result handshake.
module tb_tdoa_collector;
  localparam int NUM_CH = 3;
  localparam int WIDTH  = 32;
  localparam int WINDOW = 100;

  typedef struct {
    logic [2:0]                   r;
    logic [NUM_CH-1:0][WIDTH-1:0] d;
    int                           rise;
  } item_t;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NUM_CH-1:0][WIDTH-1:0] ts_v;
  logic [NUM_CH-1:0]            ts_valid;
  logic [NUM_CH-1:0]            ts_ack;
  logic                         evt_valid;
  logic                         evt_ready;
  logic [NUM_CH*WIDTH-1:0]      evt_delta;
  logic [2:0]                   evt_ref_ch;
`ifdef TDOA_DROP_CNT_EN
  logic [15:0]                  drop_cnt;
`endif

  item_t q[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    rise_cyc = 0;
  logic  vld_q = 1'b0;

  tdoa_collector #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ts_in      (ts_v),
    .ts_valid   (ts_valid),
    .ts_ack     (ts_ack),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_delta  (evt_delta),
    .evt_ref_ch (evt_ref_ch)
`ifdef TDOA_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Holds a stamp valid until acked, like the detector timers do.
  task automatic send(input int ch, input logic [WIDTH-1:0] st, input bit lat_chk,
                      output int ack_cyc);
    int c0, n;
    ts_v[ch] = st;
    ts_valid[ch] = 1'b1;
    c0 = cyc;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ts_ack[ch] && n < 500);
    chk($sformatf("ack_seen%0d", ch), ts_ack[ch], 1);
    if (lat_chk) chk($sformatf("ack_lat%0d", ch), cyc - c0, 1);
    ack_cyc = cyc;
    ts_valid[ch] = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("ack_pulse%0d", ch), ts_ack[ch], 0);
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(posedge clk); n++;
    end while (q.size() != 0 && n < 300);
    #1;
    chk("drain", q.size(), 0);
  endtask

  task automatic run_evt(input logic [NUM_CH-1:0][WIDTH-1:0] s, input int o0, o1, o2,
                         input logic [2:0] r, input logic [NUM_CH-1:0][WIDTH-1:0] d,
                         input bit do_drain);
    item_t e;
    int mx, a0, a1, a2;
    mx = (o0 > o1) ? o0 : o1;
    mx = (mx > o2) ? mx : o2;
    e.r = r; e.d = d; e.rise = cyc + mx + 3;
    q.push_back(e);
    fork
      begin if (o0 > 0) begin repeat (o0) @(posedge clk); #1; end send(0, s[0], 1, a0); end
      begin if (o1 > 0) begin repeat (o1) @(posedge clk); #1; end send(1, s[1], 1, a1); end
      begin if (o2 > 0) begin repeat (o2) @(posedge clk); #1; end send(2, s[2], 1, a2); end
    join
    if (do_drain) drain();
  endtask

  // Earliest = lowest channel that no other channel precedes (wrap-aware).
  function automatic item_t model(input logic [NUM_CH-1:0][WIDTH-1:0] s);
    item_t m;
    logic signed [WIDTH-1:0] sd;
    bit ok;
    int rr = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      ok = 1'b1;
      for (int j = 0; j < NUM_CH; j++) begin
        sd = s[j] - s[i];
        if (sd < 0) ok = 1'b0;
      end
      if (ok) rr = i;
    end
    m.r = 3'(rr);
    for (int i = 0; i < NUM_CH; i++) m.d[i] = s[i] - s[rr];
    m.rise = 0;
    return m;
  endfunction

  always @(negedge clk) begin
    item_t e;
    if (!rst && evt_valid && !vld_q) begin
      rise_cyc = cyc;
      chk("evt_expected", q.size() != 0, 1);
    end
    if (!rst && evt_valid && evt_ready && q.size() != 0) begin
      e = q.pop_front();
      chk("rise_cycle", rise_cyc, e.rise);
      chk("ref_ch", evt_ref_ch, e.r);
      for (int i = 0; i < NUM_CH; i++)
        chk($sformatf("delta%0d", i), evt_delta[i*WIDTH +: WIDTH], e.d[i]);
    end
    vld_q <= evt_valid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [NUM_CH-1:0][WIDTH-1:0] s, d;
    item_t m;
    int a0, a1, r_cyc, base;
    rst = 1'b1; evt_ready = 1'b1; ts_valid = '0; ts_v = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_ack", ts_ack, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_delta", evt_delta, 0);
    chk("rst_ref", evt_ref_ch, 0);
`ifdef TDOA_DROP_CNT_EN
    chk("rst_drop", drop_cnt, 0);
`endif
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;

    // Staggered arrivals.
    s = {32'd1005, 32'd1002, 32'd1000}; d = {32'd5, 32'd2, 32'd0};
    run_evt(s, 0, 2, 5, 3'd0, d, 1);
    // Simultaneous arrivals, tie on the earliest.
    s = {32'd40, 32'd40, 32'd50}; d = {32'd0, 32'd0, 32'd10};
    run_evt(s, 0, 0, 0, 3'd1, d, 1);
    // Counter wrap.
    s = {32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFE}; d = {32'd1, 32'd5, 32'd0};
    run_evt(s, 1, 0, 3, 3'd0, d, 1);

    // Timeout: ch2 never arrives.
    fork
      send(0, 32'd77, 1, a0);
      send(1, 32'd88, 1, a1);
    join
    repeat (WINDOW + 20) @(posedge clk); #1;
    chk("timeout_no_evt", evt_valid, 0);
`ifdef TDOA_DROP_CNT_EN
    chk("drop_cnt", drop_cnt, 1);
`endif
    // Last channel captured on the final window edge completes the event.
    s = {32'd200, 32'd9, 32'd7}; d = {32'd193, 32'd2, 32'd0};
    run_evt(s, 0, 0, WINDOW + 1, 3'd0, d, 1);
`ifdef TDOA_DROP_CNT_EN
    chk("drop_cnt_hold", drop_cnt, 1);
`endif

    // Back-pressure: ch0 re-asserts while the result waits.
    evt_ready = 1'b0;
    s = {32'd200, 32'd300, 32'd100}; d = {32'd100, 32'd200, 32'd0};
    run_evt(s, 0, 0, 0, 3'd0, d, 0);
    fork
      send(0, 32'd500, 0, a0);
      begin repeat (20) @(posedge clk); #1; r_cyc = cyc; evt_ready = 1'b1; end
    join
    chk("ack_after_accept", a0, r_cyc + 2);
    m.r = 3'd2; m.d = {32'd0, 32'd20, 32'd10}; m.rise = cyc + 3;
    q.push_back(m);
    fork
      send(1, 32'd510, 1, a1);
      send(2, 32'd490, 1, a1);
    join
    drain();

    // Randomised events near a random (possibly wrapping) base.
    for (int k = 0; k < 4; k++) begin
      base = int'($urandom);
      for (int i = 0; i < NUM_CH; i++) s[i] = WIDTH'(base) + WIDTH'($urandom_range(0, 5000));
      m = model(s);
      run_evt(s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), m.r, m.d, 1);
    end

    // Reset while collecting discards the partial event.
    send(0, 32'd1234, 1, a0);
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("rst2_ack", ts_ack, 0);
    chk("rst2_valid", evt_valid, 0);
    chk("rst2_delta", evt_delta, 0);
    chk("rst2_ref", evt_ref_ch, 0);
`ifdef TDOA_DROP_CNT_EN
    chk("rst2_drop", drop_cnt, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    s = {32'd7, 32'd6, 32'd5}; d = {32'd2, 32'd1, 32'd0};
    run_evt(s, 0, 0, 0, 3'd0, d, 1);

    repeat (5) @(posedge clk); #1;
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
